// File: rtl/axi4_mem_responder_pkg.sv
// Shared types and sizing helpers for the AXI4 memory responder.
package axi4_mem_responder_pkg;

    typedef enum logic [1:0] {
        WIDLE,
        WDATA,
        WRESP
    } wr_state_t;

    typedef enum logic {
        RIDLE,
        RBURST
    } rd_state_t;

    function automatic int unsigned lp_byte_shift(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned lp_idx_width(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

    localparam int unsigned LP_BYTE_SHIFT = lp_byte_shift(512);
    localparam int unsigned LP_IDX_WIDTH  = lp_idx_width(512);
    // Beat counter holds awlen/arlen + 1, i.e. up to 256.
    localparam int unsigned LP_CNT_WIDTH  = 9;

endpackage

// File: rtl/axi4_mem_rd_skid.sv
// Two-entry valid/ready skid FIFO carrying read data and last; occupancy feeds the RAM issue gate.
module axi4_mem_rd_skid #(
    parameter int unsigned DW = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    occupancy_c
);

    logic          vld0_q, vld0_d, vld1_q, vld1_d;
    logic          last0_q, last0_d, last1_q, last1_d;
    logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
    logic          pop;

    assign pop = vld0_q & out_ready;

    // Entry 0 is the head presented on R; entry 1 absorbs the beat in flight during a stall.
    always_comb begin
        vld0_d  = vld0_q;
        vld1_d  = vld1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        if (pop) begin
            if (vld1_q) begin
                vld0_d  = 1'b1;
                data0_d = data1_q;
                last0_d = last1_q;
                vld1_d  = in_valid;
                if (in_valid) begin
                    data1_d = in_data;
                    last1_d = in_last;
                end
            end else begin
                vld0_d = in_valid;
                vld1_d = 1'b0;
                if (in_valid) begin
                    data0_d = in_data;
                    last0_d = in_last;
                end
            end
        end else if (in_valid) begin
            if (!vld0_q) begin
                vld0_d  = 1'b1;
                data0_d = in_data;
                last0_d = in_last;
            end else if (!vld1_q) begin
                vld1_d  = 1'b1;
                data1_d = in_data;
                last1_d = in_last;
            end
        end
        if (!vld0_d) begin
            last0_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
        end
    end

    assign out_valid   = vld0_q;
    assign out_data    = data0_q;
    assign out_last    = last0_q;
    assign occupancy_c = {vld0_q & vld1_q, vld0_q ^ vld1_q};

endmodule

// File: rtl/axi4_mem_responder.sv
// BRAM-backed AXI4 slave memory: independent write and read FSMs over one simple-dual-port RAM.
module axi4_mem_responder
    import axi4_mem_responder_pkg::*;
#(
    parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 64,
    parameter int unsigned                   C_S_AXI_DATA_WIDTH = 512,
    parameter int unsigned                   C_MEM_DEPTH_WORDS  = 512,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic                            wlast_err
);

    localparam int unsigned AW         = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW         = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW         = DW / 8;
    localparam int unsigned BYTE_SHIFT = lp_byte_shift(DW);
    localparam int unsigned IDX_W      = lp_idx_width(C_MEM_DEPTH_WORDS);
    localparam int unsigned CNT_W      = LP_CNT_WIDTH;

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = (addr - C_BASE_ADDR) >> BYTE_SHIFT;
        return IDX_W'(off);
    endfunction

    // ---------------- write channel ----------------
    wr_state_t        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             wlast_err_q, wlast_err_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic             aw_hs, w_hs, b_hs, wr_final_beat, wr_end;

    assign aw_hs         = s_axi_awvalid & awready_q;
    assign w_hs          = s_axi_wvalid & wready_q;
    assign b_hs          = bvalid_q & s_axi_bready;
    assign wr_final_beat = (wr_cnt_q == CNT_W'(1));
    assign wr_end        = w_hs & (wr_final_beat | s_axi_wlast);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_state_q <= WIDLE;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WIDLE:   if (aw_hs)  wr_state_d = WDATA;
            WDATA:   if (wr_end) wr_state_d = WRESP;
            WRESP:   if (b_hs)   wr_state_d = WIDLE;
            default: wr_state_d = WIDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_comb begin
        awready_d = (wr_state_d == WIDLE);
        wready_d  = (wr_state_d == WDATA);
        bvalid_d  = (wr_state_d == WRESP);
    end

    always_comb begin
        wr_idx_d    = wr_idx_q;
        wr_cnt_d    = wr_cnt_q;
        wlast_err_d = wlast_err_q;
        if (aw_hs) begin
            wr_idx_d = word_idx(s_axi_awaddr);
            wr_cnt_d = CNT_W'(s_axi_awlen) + CNT_W'(1);
        end else if (w_hs) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
            wr_cnt_d = wr_cnt_q - CNT_W'(1);
            if (s_axi_wlast != wr_final_beat) begin
                wlast_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_idx_q    <= '0;
            wr_cnt_q    <= '0;
            wlast_err_q <= 1'b0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            wr_cnt_q    <= wr_cnt_d;
            wlast_err_q <= wlast_err_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
        end
    end

    // ---------------- read channel ----------------
    rd_state_t        rd_state_q, rd_state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             arready_q, arready_d;
    logic             ram_rvld_q, ram_rvld_d;
    logic             ram_rlast_q, ram_rlast_d;
    logic [DW-1:0]    ram_rdata_q;
    logic             ar_hs, r_pop, ram_re, rd_room;
    logic [2:0]       rd_pending;
    logic [1:0]       skid_occ;
    logic             skid_valid, skid_last;
    logic [DW-1:0]    skid_data;

    assign ar_hs      = s_axi_arvalid & arready_q;
    assign r_pop      = skid_valid & s_axi_rready;
    // Beats held in the skid plus the one in the RAM pipe must fit once this cycle's pop drains.
    assign rd_pending = {1'b0, skid_occ} + {2'b0, ram_rvld_q};
    assign rd_room    = rd_pending < (3'd2 + {2'b0, r_pop});
    assign ram_re     = (rd_state_q == RBURST) && (rd_cnt_q != '0) && rd_room;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            rd_state_q <= RIDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RIDLE:   if (ar_hs)                   rd_state_d = RBURST;
            RBURST:  if (r_pop && skid_last)      rd_state_d = RIDLE;
            default: rd_state_d = RIDLE;
        endcase
    end

    always_comb begin
        arready_d = (rd_state_d == RIDLE);
    end

    always_comb begin
        rd_idx_d    = rd_idx_q;
        rd_cnt_d    = rd_cnt_q;
        ram_rvld_d  = ram_re;
        ram_rlast_d = ram_re && (rd_cnt_q == CNT_W'(1));
        if (ar_hs) begin
            rd_idx_d = word_idx(s_axi_araddr);
            rd_cnt_d = CNT_W'(s_axi_arlen) + CNT_W'(1);
        end else if (ram_re) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            rd_idx_q    <= '0;
            rd_cnt_q    <= '0;
            arready_q   <= 1'b1;
            ram_rvld_q  <= 1'b0;
            ram_rlast_q <= 1'b0;
        end else begin
            rd_idx_q    <= rd_idx_d;
            rd_cnt_q    <= rd_cnt_d;
            arready_q   <= arready_d;
            ram_rvld_q  <= ram_rvld_d;
            ram_rlast_q <= ram_rlast_d;
        end
    end

    // ---------------- simple-dual-port RAM (read-first, contents survive reset) ----------------
    logic [DW-1:0] mem [C_MEM_DEPTH_WORDS];

    always_ff @(posedge ap_clk) begin
        if (w_hs) begin
            for (int b = 0; b < SW; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[wr_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ram_re) begin
            ram_rdata_q <= mem[rd_idx_q];
        end
    end

    axi4_mem_rd_skid #(
        .DW (DW)
    ) u_rd_skid (
        .clk         (ap_clk),
        .rst         (areset),
        .in_valid    (ram_rvld_q),
        .in_data     (ram_rdata_q),
        .in_last     (ram_rlast_q),
        .out_valid   (skid_valid),
        .out_ready   (s_axi_rready),
        .out_data    (skid_data),
        .out_last    (skid_last),
        .occupancy_c (skid_occ)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = skid_valid;
    assign s_axi_rdata   = skid_data;
    assign s_axi_rlast   = skid_last;
    assign wlast_err     = wlast_err_q;

endmodule
